// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO controller: captures bytes from a UART receiver holding stage into a
// show-ahead FIFO, with a WAIT/HOLD handshake and a sticky overrun flag.
module rx_fifo_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RDA,
    input  logic [7:0]    RxD_data,
    output logic          rd_rx,
    input  logic          rd_req,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          clr_ovr
);

    typedef enum logic {StWait, StHold} state_e;

    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    state_e          state_q;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     count_q;
    logic            overrun_q;
    logic [7:0]      mem [DEPTH];

    logic            pop;
    logic            wr;
    logic            discard;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCnt);
    assign count   = count_q;
    assign overrun = overrun_q;

    // Acknowledge is combinational so the receiver frees its stage in the same cycle.
    assign rd_rx   = (state_q == StWait) && RDA && !rst;
    assign pop     = rd_req && !empty && !rst;
    assign wr      = rd_rx && (!full || pop);
    assign discard = rd_rx && !wr;

    assign rd_data = empty ? 8'h00 : mem[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StWait;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                StWait: if (rd_rx) state_q <= StHold;
                StHold: state_q <= StWait;
                default: state_q <= StWait;
            endcase
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            unique case ({wr, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A discard in the same cycle as a clear must leave the flag set.
            if (discard)      overrun_q <= 1'b1;
            else if (clr_ovr) overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q] <= RxD_data;
    end

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_rx_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst;
    logic          RDA;
    logic [7:0]    RxD_data;
    logic          rd_rx;
    logic          rd_req;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          clr_ovr;

    int vectors;
    int miscompares;
    logic last_ack;

    rx_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .RDA      (RDA),
        .RxD_data (RxD_data),
        .rd_rx    (rd_rx),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inputs for one cycle: rd_rx sampled before the edge, outputs settle 1ns after it.
    task automatic tick(input logic r, input logic a, input logic [7:0] d,
                        input logic q, input logic c);
        rst = r; RDA = a; RxD_data = d; rd_req = q; clr_ovr = c;
        #1;
        last_ack = rd_rx;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
        vectors++; if (last_ack !== 1'b0) begin miscompares++; $display("FAIL reset_rd_rx: got %b want 0", last_ack); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_single_byte();
        tick(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL single_ack: got %b want 1", last_ack); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count); end
        vectors++; if (rd_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", rd_data); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %b want 0", empty); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b0) begin miscompares++; $display("FAIL single_hold_ack: got %b want 0", last_ack); end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_pop_empty: got %b want 1", empty); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL single_pop_data: got %h want 00", rd_data); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 9; i++) begin
            tick(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL fill_ack[%0d]: got %b want 1", i, last_ack); end
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            if (i == 7) begin
                vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fill_full7: got %b want 0", full); end
            end
            if (i == 8) begin
                vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full8: got %b want 1", full); end
                vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL fill_ovr8: got %b want 0", overrun); end
            end
        end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL fill_overrun: got %b want 1", overrun); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count: got %0d want 8", count); end
        for (int i = 1; i <= 8; i++) begin
            vectors++; if (rd_data !== 8'(i)) begin miscompares++; $display("FAIL fill_pop[%0d]: got %h want %h", i, rd_data, 8'(i)); end
            tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fill_drained: got %b want 1", empty); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL fill_clr: got %b want 0", overrun); end
    endtask

    task automatic test_wrap_simultaneous();
        // Write-and-pop at count==1: old head returned, new byte becomes head.
        tick(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        vectors++; if (rd_data !== 8'h41) begin miscompares++; $display("FAIL c1_oldhead: got %h want 41", rd_data); end
        tick(1'b0, 1'b1, 8'h42, 1'b1, 1'b0);
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL c1_count: got %0d want 1", count); end
        vectors++; if (rd_data !== 8'h42) begin miscompares++; $display("FAIL c1_newhead: got %h want 42", rd_data); end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL wrap_ack: got %b want 1", last_ack); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL wrap_count: got %0d want 8", count); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL wrap_ovr: got %b want 0", overrun); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'hEE : 8'(8'h11 + i);
            vectors++; if (rd_data !== exp) begin miscompares++; $display("FAIL wrap_pop[%0d]: got %h want %h", i, rd_data, exp); end
            tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_hold_guard();
        tick(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL hold_ack1: got %b want 1", last_ack); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL hold_count1: got %0d want 1", count); end
        tick(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b0) begin miscompares++; $display("FAIL hold_ack2: got %b want 0", last_ack); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL hold_count2: got %0d want 1", count); end
        tick(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL hold_ack3: got %b want 1", last_ack); end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_overrun_clear();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL race_ack: got %b want 1", last_ack); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL race_setwins: got %b want 1", overrun); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL race_clear: got %b want 0", overrun); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL race_count: got %0d want 8", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL rmid_count5: got %0d want 5", count); end
        tick(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b0) begin miscompares++; $display("FAIL rmid_ack: got %b want 0", last_ack); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rmid_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rmid_empty: got %b want 1", empty); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rmid_ovr: got %b want 0", overrun); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL rmid_data: got %h want 00", rd_data); end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rmid_emptypop: got %0d want 0", count); end
        // FSM back in WAIT: a still-pending byte is captured right away.
        tick(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        vectors++; if (last_ack !== 1'b1) begin miscompares++; $display("FAIL rmid_recapture_ack: got %b want 1", last_ack); end
        vectors++; if (rd_data !== 8'h77) begin miscompares++; $display("FAIL rmid_recapture_data: got %h want 77", rd_data); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       cooldown;
        logic       ovr;
        logic       exp_ack;
        logic [7:0] exp_data;
        logic       do_pop;
        logic       do_wr;
        cooldown = 1'b0;
        ovr      = 1'b0;
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            RDA      = ($urandom_range(0, 2) != 0);
            RxD_data = 8'($urandom);
            rd_req   = ($urandom_range(0, 2) == 0);
            clr_ovr  = ($urandom_range(0, 9) == 0);
            #1;
            exp_ack  = RDA && !cooldown && !rst;
            exp_data = (q.size() > 0) ? q[0] : 8'h00;
            vectors++; if (rd_rx !== exp_ack) begin miscompares++; $display("FAIL rnd_ack[%0d]: got %b want %b", n, rd_rx, exp_ack); end
            vectors++; if (rd_data !== exp_data) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h want %h", n, rd_data, exp_data); end
            vectors++; if (count !== (AW+1)'(q.size())) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, count, q.size()); end
            vectors++; if (empty !== (q.size() == 0)) begin miscompares++; $display("FAIL rnd_empty[%0d]: got %b want %b", n, empty, q.size() == 0); end
            vectors++; if (full !== (q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_full[%0d]: got %b want %b", n, full, q.size() == DEPTH); end
            vectors++; if (overrun !== ovr) begin miscompares++; $display("FAIL rnd_ovr[%0d]: got %b want %b", n, overrun, ovr); end
            @(posedge clk);
            if (rst) begin
                q.delete();
                cooldown = 1'b0;
                ovr      = 1'b0;
            end else begin
                do_pop = rd_req && (q.size() > 0);
                do_wr  = exp_ack && ((q.size() < DEPTH) || do_pop);
                if (do_pop) void'(q.pop_front());
                if (do_wr) q.push_back(RxD_data);
                if (exp_ack && !do_wr) ovr = 1'b1;
                else if (clr_ovr) ovr = 1'b0;
                cooldown = exp_ack;
            end
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; RDA = 1'b0; RxD_data = 8'h00; rd_req = 1'b0; clr_ovr = 1'b0;
        last_ack = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_fill_overrun();
        test_wrap_simultaneous();
        test_hold_guard();
        test_overrun_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
